// File: rtl/mem_port_scheduler.sv
// Single-ported data-memory scheduler: arbitrates two load and two store buffers onto one port
// and returns load results over the CDB. Optional RAW hazard blocking: MEM_SCHED_RAW_CHECK_EN.
module mem_port_scheduler #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  ld_req,
  input  logic [3:0]  ld_tag0,
  input  logic [3:0]  ld_tag1,
  input  logic [31:0] ld_addr0,
  input  logic [31:0] ld_addr1,
  output logic [1:0]  ld_ack,
  input  logic [1:0]  st_req,
  input  logic [31:0] st_addr0,
  input  logic [31:0] st_addr1,
  input  logic [31:0] st_data0,
  input  logic [31:0] st_data1,
  output logic [1:0]  st_ack,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        cdb_req,
  output logic [3:0]  cdb_tag,
  output logic [31:0] cdb_data,
  input  logic        cdb_grant,
  output logic        busy
);

  localparam logic [3:0] StarveMax = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {StIdle, StRead, StWaitCdb} state_e;

  state_e      state_q, state_d;
  logic        rr_q, rr_d;
  logic [3:0]  starve_cnt_q, starve_cnt_d;
  logic        cdb_req_q, cdb_req_d;
  logic [3:0]  cdb_tag_q, cdb_tag_d;
  logic [31:0] cdb_data_q, cdb_data_d;

  logic [1:0]  ld_elig;
  logic        st_grant, ld_grant;
  logic        ld_sel, st_sel;

`ifdef MEM_SCHED_RAW_CHECK_EN
  // A load may not bypass a pending store to the same address.
  logic [1:0] raw_hit;
  assign raw_hit[0] = (st_req[0] && (st_addr0 == ld_addr0)) ||
                      (st_req[1] && (st_addr1 == ld_addr0));
  assign raw_hit[1] = (st_req[0] && (st_addr0 == ld_addr1)) ||
                      (st_req[1] && (st_addr1 == ld_addr1));
  assign ld_elig    = ld_req & ~raw_hit;
`else
  assign ld_elig = ld_req;
`endif

  assign st_grant = (|st_req) && (!(|ld_elig) || (starve_cnt_q == StarveMax));
  assign ld_grant = (|ld_elig) && !st_grant;
  assign ld_sel   = (ld_elig == 2'b11) ? rr_q : ld_elig[1];
  assign st_sel   = !st_req[0];

  always_comb begin
    state_d      = state_q;
    rr_d         = rr_q;
    starve_cnt_d = starve_cnt_q;
    cdb_req_d    = cdb_req_q;
    cdb_tag_d    = cdb_tag_q;
    cdb_data_d   = cdb_data_q;
    ld_ack       = 2'b00;
    st_ack       = 2'b00;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;

    unique case (state_q)
      StIdle: begin
        if (ld_grant) begin
          ld_ack    = ld_sel ? 2'b10 : 2'b01;
          mem_addr  = ld_sel ? ld_addr1 : ld_addr0;
          cdb_tag_d = ld_sel ? ld_tag1 : ld_tag0;
          rr_d      = !ld_sel;
          state_d   = StRead;
          if ((|st_req) && (starve_cnt_q < StarveMax)) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
          end
        end else if (st_grant) begin
          st_ack       = st_sel ? 2'b10 : 2'b01;
          mem_we       = 1'b1;
          mem_addr     = st_sel ? st_addr1 : st_addr0;
          mem_wdata    = st_sel ? st_data1 : st_data0;
          starve_cnt_d = '0;
        end
      end
      StRead: begin
        cdb_data_d = mem_rdata;
        cdb_req_d  = 1'b1;
        state_d    = StWaitCdb;
      end
      StWaitCdb: begin
        if (cdb_grant) begin
          cdb_req_d = 1'b0;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Acks and writes are combinational, so block them while reset is asserted.
    if (!rst_n) begin
      ld_ack = 2'b00;
      st_ack = 2'b00;
      mem_we = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      rr_q         <= 1'b0;
      starve_cnt_q <= '0;
      cdb_req_q    <= 1'b0;
      cdb_tag_q    <= '0;
      cdb_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      rr_q         <= rr_d;
      starve_cnt_q <= starve_cnt_d;
      cdb_req_q    <= cdb_req_d;
      cdb_tag_q    <= cdb_tag_d;
      cdb_data_q   <= cdb_data_d;
    end
  end

  assign cdb_req  = cdb_req_q;
  assign cdb_tag  = cdb_tag_q;
  assign cdb_data = cdb_data_q;
  assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_mem_port_scheduler.sv
// Self-checking bench for mem_port_scheduler: a small memory model plus a scoreboard of
// expected CDB results (tag, data) compared when each result is granted.
module tb_mem_port_scheduler;

  logic        clk;
  logic        rst_n;
  logic [1:0]  ld_req;
  logic [3:0]  ld_tag0, ld_tag1;
  logic [31:0] ld_addr0, ld_addr1;
  logic [1:0]  ld_ack;
  logic [1:0]  st_req;
  logic [31:0] st_addr0, st_addr1, st_data0, st_data1;
  logic [1:0]  st_ack;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        cdb_req;
  logic [3:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic        cdb_grant;
  logic        busy;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0]  tag;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  mem_port_scheduler #(.STARVE_LIMIT(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ld_req    (ld_req),
    .ld_tag0   (ld_tag0),
    .ld_tag1   (ld_tag1),
    .ld_addr0  (ld_addr0),
    .ld_addr1  (ld_addr1),
    .ld_ack    (ld_ack),
    .st_req    (st_req),
    .st_addr0  (st_addr0),
    .st_addr1  (st_addr1),
    .st_data0  (st_data0),
    .st_data1  (st_data1),
    .st_ack    (st_ack),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .cdb_req   (cdb_req),
    .cdb_tag   (cdb_tag),
    .cdb_data  (cdb_data),
    .cdb_grant (cdb_grant),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read memory: data appears the cycle after the address.
  logic [31:0] mem [256];
  always @(posedge clk) begin
    if (!rst_n) begin
      mem[8'h10] <= 32'h0000_00AB;
      mem[8'h14] <= 32'h0000_00CD;
    end else if (mem_we) begin
      mem[mem_addr[7:0]] <= mem_wdata;
    end
    mem_rdata <= mem[mem_addr[7:0]];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && cdb_req && cdb_grant) begin
      if (sb.size() == 0) begin
        check("sb_unexpected", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("cdb_tag", {28'd0, cdb_tag}, {28'd0, e.tag});
        check("cdb_data", cdb_data, e.data);
      end
    end
  end

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic wait_ack(output logic [3:0] acks);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ld_ack != 2'b00 || st_ack != 2'b00) begin
        acks = {st_ack, ld_ack};
        return;
      end
    end
    acks = 4'b0000;
    check("ack_timeout", 32'd0, 32'd1);
  endtask

  task automatic serve_cdb;
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (cdb_req) seen = 1'b1;
    end
    if (!seen) begin
      check("cdb_timeout", 32'd0, 32'd1);
    end else begin
      cyc();
      cdb_grant = 1'b1;
      @(negedge clk);
      cyc();
      cdb_grant = 1'b0;
    end
  endtask

  initial begin
    logic [3:0] a;
    ld_req = '0; ld_tag0 = '0; ld_tag1 = '0; ld_addr0 = '0; ld_addr1 = '0;
    st_req = '0; st_addr0 = '0; st_addr1 = '0; st_data0 = '0; st_data1 = '0;
    cdb_grant = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_cdb_req", {31'd0, cdb_req}, 32'd0);
    check("rst_cdb_tag", {28'd0, cdb_tag}, 32'd0);
    check("rst_cdb_data", cdb_data, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    do_reset();

    // Stray grant with no pending result.
    cdb_grant = 1'b1;
    @(negedge clk);
    check("stray_grant_busy", {31'd0, busy}, 32'd0);
    check("stray_grant_req", {31'd0, cdb_req}, 32'd0);
    cyc();
    cdb_grant = 1'b0;

    // Single load, exact latency and hold until grant.
    ld_req = 2'b01; ld_tag0 = 4'd3; ld_addr0 = 32'h10;
    sb.push_back('{tag: 4'd3, data: 32'hAB});
    @(negedge clk);
    check("t1_ack_c0", {30'd0, ld_ack}, 32'b01);
    check("t1_addr_c0", mem_addr, 32'h10);
    check("t1_we_c0", {31'd0, mem_we}, 32'd0);
    cyc();
    ld_req = 2'b00;
    @(negedge clk);
    check("t1_busy_c1", {31'd0, busy}, 32'd1);
    check("t1_req_c1", {31'd0, cdb_req}, 32'd0);
    check("t1_noack_c1", {30'd0, ld_ack}, 32'd0);
    @(negedge clk);
    check("t1_req_c2", {31'd0, cdb_req}, 32'd1);
    check("t1_tag_c2", {28'd0, cdb_tag}, 32'd3);
    check("t1_data_c2", cdb_data, 32'hAB);
    repeat (2) begin
      @(negedge clk);
      check("t1_hold_req", {31'd0, cdb_req}, 32'd1);
      check("t1_hold_data", cdb_data, 32'hAB);
    end
    serve_cdb();
    @(negedge clk);
    check("t1_req_drop", {31'd0, cdb_req}, 32'd0);
    check("t1_idle", {31'd0, busy}, 32'd0);

    // Both loads always requesting: round-robin alternation.
    do_reset();
    ld_req = 2'b11; ld_tag0 = 4'd1; ld_tag1 = 4'd2; ld_addr0 = 32'h10; ld_addr1 = 32'h14;
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) sb.push_back('{tag: 4'd1, data: 32'hAB});
      else            sb.push_back('{tag: 4'd2, data: 32'hCD});
      wait_ack(a);
      check("rr_ack", {28'd0, a}, (k % 2 == 0) ? 32'b0001 : 32'b0010);
      serve_cdb();
    end
    ld_req = 2'b00;

    // Store then load to the same address.
    do_reset();
    st_req = 2'b01; st_addr0 = 32'h20; st_data0 = 32'h55;
    @(negedge clk);
    check("t3_st_ack", {30'd0, st_ack}, 32'b01);
    check("t3_we", {31'd0, mem_we}, 32'd1);
    check("t3_addr", mem_addr, 32'h20);
    check("t3_wdata", mem_wdata, 32'h55);
    cyc();
    st_req = 2'b00; ld_req = 2'b01; ld_tag0 = 4'd5; ld_addr0 = 32'h20;
    sb.push_back('{tag: 4'd5, data: 32'h55});
    @(negedge clk);
    check("t3_ld_ack_c1", {30'd0, ld_ack}, 32'b01);
    check("t3_we_c1", {31'd0, mem_we}, 32'd0);
    cyc();
    ld_req = 2'b00;
    @(negedge clk);
    check("t3_idle_addr", mem_addr, 32'd0);
    check("t3_idle_we", {31'd0, mem_we}, 32'd0);
    serve_cdb();

    // Back-to-back stores, store 0 first.
    st_req = 2'b11; st_addr0 = 32'h28; st_data0 = 32'h11; st_addr1 = 32'h2C; st_data1 = 32'h22;
    @(negedge clk);
    check("b2b_ack0", {30'd0, st_ack}, 32'b01);
    check("b2b_addr0", mem_addr, 32'h28);
    cyc();
    st_req = 2'b10;
    @(negedge clk);
    check("b2b_ack1", {30'd0, st_ack}, 32'b10);
    check("b2b_wdata1", mem_wdata, 32'h22);
    cyc();
    st_req = 2'b00;

    // Starvation: store held against continuous loads.
    do_reset();
    st_req = 2'b01; st_addr0 = 32'h30; st_data0 = 32'h77;
    ld_req = 2'b11; ld_tag0 = 4'd1; ld_tag1 = 4'd2; ld_addr0 = 32'h10; ld_addr1 = 32'h14;
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) sb.push_back('{tag: 4'd1, data: 32'hAB});
      else            sb.push_back('{tag: 4'd2, data: 32'hCD});
      wait_ack(a);
      check("starve_ld", {28'd0, a}, (k % 2 == 0) ? 32'b0001 : 32'b0010);
      serve_cdb();
    end
    wait_ack(a);
    check("starve_st", {28'd0, a}, 32'b0100);
    check("starve_we", {31'd0, mem_we}, 32'd1);
    cyc();
    st_req = 2'b00;
    sb.push_back('{tag: 4'd1, data: 32'hAB});
    @(negedge clk);
    check("starve_cnt_clr", {28'd0, dut.starve_cnt_q}, 32'd0);
    check("starve_ld_after", {30'd0, ld_ack}, 32'b01);
    cyc();
    ld_req = 2'b00;
    serve_cdb();

    // Reset while waiting for the CDB.
    do_reset();
    ld_req = 2'b01; ld_tag0 = 4'd7; ld_addr0 = 32'h10;
    wait_ack(a);
    check("rst_wait_ack", {28'd0, a}, 32'b0001);
    repeat (2) @(negedge clk);
    check("rst_wait_req", {31'd0, cdb_req}, 32'd1);
    cyc();
    rst_n = 1'b0;
    #1;
    check("rst_async_req", {31'd0, cdb_req}, 32'd0);
    check("rst_async_busy", {31'd0, busy}, 32'd0);
    check("rst_async_ack", {30'd0, ld_ack}, 32'd0);
    @(negedge clk);
    check("rst_hold_req", {31'd0, cdb_req}, 32'd0);
    cyc();
    rst_n = 1'b1;
    sb.push_back('{tag: 4'd7, data: 32'hAB});
    @(negedge clk);
    check("rst_reack", {30'd0, ld_ack}, 32'b01);
    cyc();
    ld_req = 2'b00;
    serve_cdb();

`ifdef MEM_SCHED_RAW_CHECK_EN
    // Same-address store blocks the load even with no starvation.
    do_reset();
    st_req = 2'b10; st_addr1 = 32'h40; st_data1 = 32'h99;
    ld_req = 2'b01; ld_tag0 = 4'd9; ld_addr0 = 32'h40;
    @(negedge clk);
    check("raw_st_first", {28'd0, st_ack, ld_ack}, 32'b1000);
    check("raw_we", {31'd0, mem_we}, 32'd1);
    cyc();
    st_req = 2'b00;
    sb.push_back('{tag: 4'd9, data: 32'h99});
    @(negedge clk);
    check("raw_ld_after", {30'd0, ld_ack}, 32'b01);
    cyc();
    ld_req = 2'b00;
    serve_cdb();
`endif

    repeat (3) @(negedge clk);
    check("sb_drained", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_port_scheduler.md
MEM_PORT_SCHEDULER -- requirements
Module: mem_port_scheduler

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: consecutive store-losing grants before stores take priority (range 1..15).
REQ-002 SHALL have ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ld_req  in  2  load request, bit i from load buffer i.
- ld_tag0, ld_tag1  in  4  RS tag of each load.
- ld_addr0, ld_addr1  in  32  effective address of each load.
- ld_ack  out  2  one-cycle accept pulse per load.
- st_req  in  2  store request, bit i from store buffer i.
- st_addr0, st_addr1  in  32  store address.
- st_data0, st_data1  in  32  store data.
- st_ack  out  2  one-cycle accept pulse per store.
- mem_we  out  1  data-memory write enable.
- mem_addr  out  32  data-memory address, shared by reads and writes.
- mem_wdata  out  32  data-memory write data.
- mem_rdata  in  32  read data, valid the cycle after the address.
- cdb_req  out  1  load result ready for the CDB.
- cdb_tag  out  4  tag of the pending result.
- cdb_data  out  32  loaded value.
- cdb_grant  in  1  CDB arbiter accepts the result this cycle.
- busy  out  1  high in any state other than IDLE.

Function
REQ-003 SHALL implement FSM IDLE -> READ -> WAIT_CDB -> IDLE; at most one memory access per cycle.
REQ-004 In IDLE, eligible loads SHALL win over eligible stores unless starve_cnt == STARVE_LIMIT, in which case a store SHALL win.
REQ-005 Between the two loads, a round-robin pointer SHALL decide; it SHALL point to the other load after each load grant (reset value: load 0 first).
REQ-006 Between the two stores, store 0 SHALL win over store 1 (buffer order equals program order).
REQ-007 Load grant in IDLE: mem_addr=ld_addrN, mem_we=0, ld_ack[N]=1 in that same cycle (combinational); tag latched; next state READ.
REQ-008 READ SHALL latch mem_rdata into cdb_data and go to WAIT_CDB; load-to-cdb_req latency is exactly 2 cycles after ack.
REQ-009 WAIT_CDB SHALL hold cdb_req=1 and stable cdb_tag/cdb_data until cdb_grant=1; on grant next state is IDLE and cdb_req is 0 the next cycle.
REQ-010 Store grant in IDLE: mem_we=1, mem_addr/mem_wdata from the chosen store, st_ack[N]=1 the same cycle; state stays IDLE, so back-to-back stores SHALL issue one per cycle.
REQ-011 starve_cnt SHALL increment (saturating at STARVE_LIMIT) on each load grant while any st_req is high, and clear on any store grant.
REQ-012 Outside a grant cycle, mem_we=0 and mem_addr=mem_wdata=0; ld_ack/st_ack SHALL never be asserted outside IDLE.
REQ-013 Requesters hold req and operands until ack and drop req the cycle after; a req that drops before ack SHALL be ignored.
REQ-014 New requests arriving in READ/WAIT_CDB SHALL wait; no request SHALL be lost or acked twice.
REQ-015 cdb_grant while cdb_req=0 SHALL be ignored.

Reset
REQ-016 On rst_n low, state=IDLE, starve_cnt=0, rr pointer=0, cdb_req=0, cdb_tag=0, cdb_data=0 and busy=0, all immediately; acks and mem_we SHALL be 0 while rst_n is low.
REQ-017 Reset during READ/WAIT_CDB SHALL discard the in-flight load without any CDB broadcast.

Configuration
REQ-018 With MEM_SCHED_RAW_CHECK_EN defined, load N SHALL be ineligible while any st_req[i]=1 has st_addr_i == ld_addrN; other arbitration is unchanged.
REQ-019 Without MEM_SCHED_RAW_CHECK_EN, no address comparison SHALL exist and loads are eligible whenever requested.

Verification
REQ-020 Bench SHALL cover:
- Single load tag=3, addr=0x10, mem[0x10]=0xAB: ld_ack[0] in cycle 0, cdb_req in cycle 2 with tag 3 and data 0xAB, held until cdb_grant.
- Both loads requested every cycle (tags 1, 2): grants alternate 0,1,0,1; cdb_tag sequence 1,2,1,2.
- Store 0 (0x20 <- 0x55) then load at 0x20: mem_we=1 in cycle 0, load acked in cycle 1, cdb_data=0x55.
- st_req[0] held with continuous loads, STARVE_LIMIT=4: store granted after exactly 4 load grants; starve_cnt then 0.
- rst_n low in WAIT_CDB: cdb_req=0 at once, busy=0; after release, pending ld_req is re-acked.
- MEM_SCHED_RAW_CHECK_EN defined, st_req[1] and ld_req[0] both at 0x40: store issues first even with starve_cnt=0; load acked the cycle after.
